// File: rtl/keypad_pkg.sv
// Shared types, defaults and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

    // Default dwell per column (1 ms at 27 MHz) and debounce depth.
    localparam int DEFAULT_SCAN_DIV       = 27000;
    localparam int DEFAULT_DEBOUNCE_SCANS = 4;

    // Key code is {row_idx[1:0], col_idx[1:0]}.
    localparam int KEY_CODE_W = 4;

    // Width of the debounce/release counters (holds up to 15).
    localparam int CNT_W = 4;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_e;

    // Index of the lowest-numbered row that reads low (rows are active-low).
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // One-hot active-low column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] limit);
        return (cnt >= limit) ? limit : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the accepted-key outputs, bundled for the scanner port.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [3:0]            row;
    logic [3:0]            col;
    logic [KEY_CODE_W-1:0] key_code;
    logic                  key_valid;
    logic                  key_held;

    // Scanner side: reads rows, drives columns and key results.
    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    // Keypad/consumer side: drives rows, observes everything else.
    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad rows.
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;

    // Resets to all ones so an idle (released) keypad is seen right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1 <= '1;
            stage2 <= '1;
        end else begin
            stage1 <= din;
            stage2 <= stage1;
        end
    end

    assign dout = stage2;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, key report.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = DEFAULT_SCAN_DIV,
    parameter int DEBOUNCE_SCANS = DEFAULT_DEBOUNCE_SCANS
) (
    input logic               clk,
    input logic               rst,
    keypad_scanner_if.master  bus
);

    localparam logic [1:0] SCAN     = ST_SCAN;
    localparam logic [1:0] DEBOUNCE = ST_DEBOUNCE;
    localparam logic [1:0] HOLD     = ST_HOLD;
    localparam logic [1:0] RELEASE  = ST_RELEASE;

    localparam logic [15:0]      DIV_LAST   = 16'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0]            rs;
    logic [15:0]           div_cnt;
    logic                  sp;
    logic [1:0]            state;
    logic [1:0]            col_idx;
    logic [1:0]            row_idx;
    logic [CNT_W-1:0]      match_cnt;
    logic [CNT_W-1:0]      rel_cnt;
    logic [KEY_CODE_W-1:0] key_code_q;
    logic                  key_valid_q;
    logic                  key_held_q;
    logic                  row_up;

    row_sync #(
        .WIDTH (4)
    ) u_row_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.row),
        .dout (rs)
    );

    // The last dwell count is the sample point where all row decisions happen.
    assign sp = (div_cnt == DIV_LAST);

    // The latched row reads high (released) on the synchronized rows.
    assign row_up = rs[row_idx];

    // Free-running dwell counter; it never stops so sample points stay periodic in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= 16'd0;
        end else if (sp) begin
            div_cnt <= 16'd0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Scan/debounce/hold/release sequencing; col_idx doubles as the latched column.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            col_idx     <= 2'd0;
            row_idx     <= 2'd0;
            match_cnt   <= '0;
            rel_cnt     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (state)
                SCAN: begin
                    if (sp) begin
                        if (rs != 4'hF) begin
                            row_idx   <= lowest_low_row(rs);
                            match_cnt <= CNT_W'(1);
                            state     <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (match_cnt >= DEB_TARGET) begin
                        key_code_q  <= {row_idx, col_idx};
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        match_cnt   <= '0;
                        state       <= HOLD;
                    end else if (sp) begin
                        if (!row_up) begin
                            match_cnt <= sat_inc(match_cnt, DEB_TARGET);
                        end else begin
                            match_cnt <= '0;
                            col_idx   <= col_idx + 2'd1;
                            state     <= SCAN;
                        end
                    end
                end
                HOLD: begin
                    if (sp && row_up) begin
                        rel_cnt <= CNT_W'(1);
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (rel_cnt >= DEB_TARGET) begin
                        key_held_q <= 1'b0;
                        rel_cnt    <= '0;
                        col_idx    <= col_idx + 2'd1;
                        state      <= SCAN;
                    end else if (sp) begin
                        if (row_up) begin
                            rel_cnt <= sat_inc(rel_cnt, DEB_TARGET);
                        end else begin
                            rel_cnt <= '0;
                            state   <= HOLD;
                        end
                    end
                end
                default: begin
                    state <= SCAN;
                end
            endcase
        end
    end

    assign bus.col       = col_drive(col_idx);
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;
    int phase_tick = 0;
    int pulse_tick = 0;
    logic found;
    logic col_moved;

    logic [3:0] idle_cols [5];

    keypad_scanner_if bus();

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    // Drives the keypad rows and the reset line.
    task automatic applyStimulus(input logic [3:0] row_value, input logic rst_value);
        bus.row = row_value;
        rst     = rst_value;
    endtask

    // Advances one clock edge, samples 1 time unit later, and tallies key_valid pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        phase_tick++;
        if (bus.key_valid === 1'b1) begin
            pulses++;
            pulse_tick = phase_tick;
        end
    endtask

    // Guards against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        idle_cols[0] = 4'b1110;
        idle_cols[1] = 4'b1101;
        idle_cols[2] = 4'b1011;
        idle_cols[3] = 4'b0111;
        idle_cols[4] = 4'b1110;

        // Reset
        applyStimulus(4'hF, 1'b1);
        repeat (3) tick();
        applyStimulus(4'hF, 1'b0);
        checkOutput("reset_col", bus.col, 4'b1110);
        checkOutput("reset_key_code", bus.key_code, 4'b0000);
        checkOutput("reset_key_valid", {3'b000, bus.key_valid}, 4'd0);
        checkOutput("reset_key_held", {3'b000, bus.key_held}, 4'd0);

        // Idle scanning: four cycles per column, wrapping back to column 0
        pulses = 0;
        for (int k = 1; k < 20; k++) begin
            tick();
            checkOutput($sformatf("idle_col_%0d", k), bus.col, idle_cols[k / 4]);
        end
        checkOutput("idle_no_valid", 4'(pulses), 4'd0);

        // Press row 2 on column 1
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.col == 4'b1101) found = 1'b1;
        end
        checkOutput("press_col_reached", {3'b000, found}, 4'd1);
        applyStimulus(4'b1011, 1'b0);
        pulses     = 0;
        phase_tick = 0;
        pulse_tick = 0;
        col_moved  = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.col != 4'b1101) col_moved = 1'b1;
        end
        checkOutput("press_pulse_count", 4'(pulses), 4'd1);
        checkOutput("press_pulse_tick", 4'(pulse_tick), 4'd13);
        checkOutput("press_key_code", bus.key_code, 4'b1001);
        checkOutput("press_key_held", {3'b000, bus.key_held}, 4'd1);
        checkOutput("press_col_frozen", bus.col, 4'b1101);
        checkOutput("press_col_never_moved", {3'b000, col_moved}, 4'd0);

        // Release: three clean sample points then one more cycle
        applyStimulus(4'hF, 1'b0);
        repeat (12) tick();
        checkOutput("release_held_before", {3'b000, bus.key_held}, 4'd1);
        tick();
        checkOutput("release_held_after", {3'b000, bus.key_held}, 4'd0);
        checkOutput("release_col_resume", bus.col, 4'b1011);
        checkOutput("release_code_kept", bus.key_code, 4'b1001);
        checkOutput("release_single_pulse", 4'(pulses), 4'd1);

        // Bounce: row 0 low for a single sample point
        applyStimulus(4'b1110, 1'b0);
        pulses = 0;
        repeat (3) tick();
        applyStimulus(4'hF, 1'b0);
        tick();
        checkOutput("bounce_col_held", bus.col, 4'b1011);
        repeat (3) tick();
        checkOutput("bounce_col_advance", bus.col, 4'b0111);
        checkOutput("bounce_no_valid", 4'(pulses), 4'd0);
        checkOutput("bounce_not_held", {3'b000, bus.key_held}, 4'd0);
        checkOutput("bounce_code_kept", bus.key_code, 4'b1001);

        // Multi-key: rows 1 and 3 low on column 0
        repeat (4) tick();
        checkOutput("multi_col_start", bus.col, 4'b1110);
        applyStimulus(4'b0101, 1'b0);
        pulses     = 0;
        phase_tick = 0;
        pulse_tick = 0;
        repeat (13) tick();
        checkOutput("multi_pulse_count", 4'(pulses), 4'd1);
        checkOutput("multi_pulse_tick", 4'(pulse_tick), 4'd13);
        checkOutput("multi_key_code", bus.key_code, 4'b0100);
        checkOutput("multi_key_held", {3'b000, bus.key_held}, 4'd1);

        // Reset while holding a key
        applyStimulus(4'hF, 1'b1);
        tick();
        checkOutput("hold_reset_col", bus.col, 4'b1110);
        checkOutput("hold_reset_held", {3'b000, bus.key_held}, 4'd0);
        checkOutput("hold_reset_code", bus.key_code, 4'b0000);
        checkOutput("hold_reset_valid", {3'b000, bus.key_valid}, 4'd0);

        // Reset in the middle of a debounce must not produce a press
        applyStimulus(4'b1110, 1'b0);
        pulses = 0;
        repeat (10) tick();
        checkOutput("deb_reset_col_before", bus.col, 4'b1110);
        applyStimulus(4'hF, 1'b1);
        tick();
        applyStimulus(4'hF, 1'b0);
        repeat (3) tick();
        checkOutput("deb_reset_col_dwell", bus.col, 4'b1110);
        tick();
        checkOutput("deb_reset_col_next", bus.col, 4'b1101);
        repeat (16) tick();
        checkOutput("deb_reset_no_valid", 4'(pulses), 4'd0);
        checkOutput("deb_reset_not_held", {3'b000, bus.key_held}, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
